// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 pins, deframes 11-bit
// frames (start, 8 data LSB first, odd parity, stop) and folds the 0xF0/0xE0
// prefix bytes into is_break/is_extended flags on the following scan code.
`timescale 1ns / 1ps

module ps2_kbd_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // The counter holds TmoLast one cycle before it would reach TIMEOUT_CYCLES.
  localparam logic [16:0] TmoLast = 17'(TIMEOUT_CYCLES - 1);

  logic       clk_s1_q, clk_s2_q, clk_s3_q;
  logic       dat_s1_q, dat_s2_q;
  logic       fall;
  logic       fall_q, bit_q;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [16:0] tmo_q, tmo_d;
  logic        break_pend_q, break_pend_d;
  logic        ext_pend_q, ext_pend_d;
  logic [7:0]  scan_code_q, scan_code_d;
  logic        scan_valid_q, scan_valid_d;
  logic        is_break_q, is_break_d;
  logic        is_ext_q, is_ext_d;
  logic        frame_err_q, frame_err_d;
  logic        timeout;
  logic        frame_good;

  assign fall = clk_s3_q & ~clk_s2_q;

  // Pin synchronisers; the fall strobe and the data bit it samples are registered together.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_dat;
      dat_s2_q <= dat_s1_q;
      fall_q   <= fall;
      if (fall) begin
        bit_q <= dat_s2_q;
      end
    end
  end

  // A fall at the same edge as the timeout keeps the frame alive.
  assign timeout    = (state_q != StIdle) && (tmo_q == TmoLast) && !fall_q;
  assign frame_good = ((^shift_q) ^ par_q) & bit_q;

  // Frame FSM, timeout counter and prefix/scan-code decode.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    break_pend_d = break_pend_q;
    ext_pend_d   = ext_pend_q;
    scan_code_d  = scan_code_q;
    is_break_d   = is_break_q;
    is_ext_d     = is_ext_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (state_q == StIdle || fall_q) ? 17'd0 : tmo_q + 17'd1;

    if (fall_q) begin
      case (state_q)
        StIdle: begin
          // A high bit while idle is line noise, not an error.
          if (!bit_q) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
          end
        end
        StData: begin
          shift_d   = {bit_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = bit_q;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (frame_good) begin
            if (shift_q == 8'hF0) begin
              break_pend_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else begin
              scan_code_d  = shift_q;
              is_break_d   = break_pend_q;
              is_ext_d     = ext_pend_q;
              scan_valid_d = 1'b1;
              break_pend_d = 1'b0;
              ext_pend_d   = 1'b0;
            end
          end else begin
            frame_err_d  = 1'b1;
            break_pend_d = 1'b0;
            ext_pend_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (timeout) begin
      state_d      = StIdle;
      frame_err_d  = 1'b1;
      break_pend_d = 1'b0;
      ext_pend_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= 17'd0;
      break_pend_q <= 1'b0;
      ext_pend_q   <= 1'b0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      is_break_q   <= 1'b0;
      is_ext_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      break_pend_q <= break_pend_d;
      ext_pend_q   <= ext_pend_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      is_break_q   <= is_break_d;
      is_ext_q     <= is_ext_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scan_code   = scan_code_q;
  assign scan_valid  = scan_valid_q;
  assign is_break    = is_break_q;
  assign is_extended = is_ext_q;
  assign frame_err   = frame_err_q;
  assign rx_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: make/break/extended sequences, parity error,
// timeout and mid-frame reset, with a pulse monitor on scan_valid/frame_err.
// The PS/2 clock is scaled down (40-cycle half period) to keep runs short.
`timescale 1ns / 1ps

module tb_ps2_kbd_rx;

  localparam int unsigned Tmo   = 200;
  localparam int          HalfP = 40;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_dat  = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid, is_break, is_extended, frame_err, rx_busy;

  ps2_kbd_rx #(.TIMEOUT_CYCLES(Tmo)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .is_break   (is_break),
    .is_extended(is_extended),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int unsigned cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int unsigned sv_cnt = 0, fe_cnt = 0, sv_cyc = 0, fe_cyc = 0;
  int unsigned width_err = 0, both_err = 0;
  logic sv_last = 1'b0, fe_last = 1'b0, busy_last = 1'b0;
  logic fe_busy = 1'b1, fe_busy_prev = 1'b0;

  always @(negedge CLOCK_50) begin
    if (scan_valid) sv_cnt <= sv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (scan_valid && !sv_last) sv_cyc <= cyc;
    if (frame_err && !fe_last) begin
      fe_cyc       <= cyc;
      fe_busy      <= rx_busy;
      fe_busy_prev <= busy_last;
    end
    if ((scan_valid && sv_last) || (frame_err && fe_last)) width_err <= width_err + 1;
    if (scan_valid && frame_err) both_err <= both_err + 1;
    sv_last   <= scan_valid;
    fe_last   <= frame_err;
    busy_last <= rx_busy;
  end

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned last_fall = 0;
  int unsigned sb, fb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_code"}, 32'(scan_code), 32'h00);
    check({tag, "_valid"}, 32'(scan_valid), 32'h0);
    check({tag, "_brk"}, 32'(is_break), 32'h0);
    check({tag, "_ext"}, 32'(is_extended), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check({tag, "_busy"}, 32'(rx_busy), 32'h0);
  endtask

  // One PS/2 bit: data set while clock high, then a low half period.
  task automatic send_bit(input logic b);
    @(posedge CLOCK_50);
    #1 ps2_dat = b;
    repeat (HalfP) @(posedge CLOCK_50);
    #1 ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HalfP) @(posedge CLOCK_50);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(1'b1);
    repeat (HalfP) @(posedge CLOCK_50);
  endtask

  task automatic snap();
    @(negedge CLOCK_50);
    sb = sv_cnt;
    fb = fe_cnt;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (5) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_idle_outputs("rst");
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    repeat (10) @(posedge CLOCK_50);

    // Make code 0x1C; scan_valid 4 edges after the stop-bit pin fall.
    snap();
    send_frame(8'h1C, 1'b0);
    @(negedge CLOCK_50);
    check("make_cnt", sv_cnt - sb, 1);
    check("make_lat", sv_cyc - last_fall, 4);
    check("make_code", 32'(scan_code), 32'h1C);
    check("make_brk", 32'(is_break), 0);
    check("make_ext", 32'(is_extended), 0);
    check("make_ferr", fe_cnt - fb, 0);
    check("make_busy", 32'(rx_busy), 0);

    // Break: F0 alone gives no strobe and leaves the old code in place.
    snap();
    send_frame(8'hF0, 1'b0);
    @(negedge CLOCK_50);
    check("f0_nopulse", sv_cnt - sb, 0);
    check("f0_hold", 32'(scan_code), 32'h1C);
    send_frame(8'h1C, 1'b0);
    @(negedge CLOCK_50);
    check("brk_cnt", sv_cnt - sb, 1);
    check("brk_code", 32'(scan_code), 32'h1C);
    check("brk_brk", 32'(is_break), 1);
    check("brk_ext", 32'(is_extended), 0);

    // Extended break E0 F0 75.
    snap();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    @(negedge CLOCK_50);
    check("xbrk_cnt", sv_cnt - sb, 1);
    check("xbrk_code", 32'(scan_code), 32'h75);
    check("xbrk_brk", 32'(is_break), 1);
    check("xbrk_ext", 32'(is_extended), 1);

    // Repeated prefixes in F0-before-E0 order.
    snap();
    send_frame(8'hF0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b0);
    @(negedge CLOCK_50);
    check("rep_cnt", sv_cnt - sb, 1);
    check("rep_code", 32'(scan_code), 32'h1C);
    check("rep_brk", 32'(is_break), 1);
    check("rep_ext", 32'(is_extended), 1);

    // Parity error after a pending F0 clears the prefix.
    snap();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b1);
    @(negedge CLOCK_50);
    check("par_ferr", fe_cnt - fb, 1);
    check("par_nopulse", sv_cnt - sb, 0);
    send_frame(8'h1C, 1'b0);
    @(negedge CLOCK_50);
    check("par_next_cnt", sv_cnt - sb, 1);
    check("par_next_brk", 32'(is_break), 0);
    check("par_next_ext", 32'(is_extended), 0);

    // Timeout: start + 4 data bits then idle clock.
    snap();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge CLOCK_50);
    check("tmo_busy_mid", 32'(rx_busy), 1);
    repeat (2 * Tmo) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("tmo_ferr", fe_cnt - fb, 1);
    check("tmo_lat", fe_cyc - last_fall, Tmo + 4);
    check("tmo_busy_drop", 32'(fe_busy), 0);
    check("tmo_busy_before", 32'(fe_busy_prev), 1);
    check("tmo_nopulse", sv_cnt - sb, 0);
    send_frame(8'h75, 1'b0);
    @(negedge CLOCK_50);
    check("tmo_next_cnt", sv_cnt - sb, 1);
    check("tmo_next_code", 32'(scan_code), 32'h75);
    check("tmo_next_ext", 32'(is_extended), 0);

    // Reset after the 5th data bit.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    @(negedge CLOCK_50);
    check("mid_busy", 32'(rx_busy), 1);
    #1 resetn = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_idle_outputs("midrst");
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    snap();
    send_frame(8'h1C, 1'b0);
    @(negedge CLOCK_50);
    check("post_cnt", sv_cnt - sb, 1);
    check("post_code", 32'(scan_code), 32'h1C);
    check("post_ferr", fe_cnt - fb, 0);

    check("pulse_width", width_err, 0);
    check("valid_and_err", both_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
